// File: rtl/register_dump.sv
// register_dump: snapshots eighteen inverted register bytes on request and
// streams them out in true polarity over a valid/ready byte interface,
// keeping a running modulo-256 sum of the bytes actually transferred.
module register_dump (
    input  logic        Clk,
    input  logic        notReset,
    input  logic        DumpReq,
    input  logic        Abort,
    input  logic [7:0]  notA,
    input  logic [7:0]  notF,
    input  logic [7:0]  notB,
    input  logic [7:0]  notC,
    input  logic [7:0]  notD,
    input  logic [7:0]  notE,
    input  logic [7:0]  notH,
    input  logic [7:0]  notL,
    input  logic [7:0]  notI,
    input  logic [7:0]  notR,
    input  logic [15:0] notPC,
    input  logic [15:0] notSP,
    input  logic [15:0] notIX,
    input  logic [15:0] notIY,
    output logic [7:0]  Dout,
    output logic        DoutValid,
    input  logic        DoutReady,
    output logic [4:0]  DoutIndex,
    output logic        DoutLast,
    output logic        Busy,
    output logic        Done,
    output logic [7:0]  DumpSum
);

    localparam int unsigned NUM_SLOTS = 18;
    localparam logic [4:0]  LAST_SLOT = 5'd17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        load;
    logic        xfer;
    logic [4:0]  slot;
    logic [7:0]  sum;
    logic [7:0]  snap    [NUM_SLOTS];
    logic [7:0]  snap_in [NUM_SLOTS];

    // Un-invert the live register inputs into slot order for capture.
    always_comb begin
        snap_in[0]  = ~notA;
        snap_in[1]  = ~notF;
        snap_in[2]  = ~notB;
        snap_in[3]  = ~notC;
        snap_in[4]  = ~notD;
        snap_in[5]  = ~notE;
        snap_in[6]  = ~notH;
        snap_in[7]  = ~notL;
        snap_in[8]  = ~notPC[15:8];
        snap_in[9]  = ~notPC[7:0];
        snap_in[10] = ~notSP[15:8];
        snap_in[11] = ~notSP[7:0];
        snap_in[12] = ~notIX[15:8];
        snap_in[13] = ~notIX[7:0];
        snap_in[14] = ~notIY[15:8];
        snap_in[15] = ~notIY[7:0];
        snap_in[16] = ~notI;
        snap_in[17] = ~notR;
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath strobes; Abort takes priority over a transfer.
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                if (DumpReq && !Abort) begin
                    load       = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                if (Abort) begin
                    next_state = IDLE;
                end else if (DoutReady) begin
                    xfer = 1'b1;
                    if (slot == LAST_SLOT) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Snapshot capture, slot counter and running checksum.
    // NOTE: the snapshot array is reset along with the control state, so
    // it must stay a flop array rather than being mapped onto a RAM macro.
    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            slot <= '0;
            sum  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                snap[i] <= '0;
            end
        end else if (load) begin
            slot <= '0;
            sum  <= '0;
            snap <= snap_in;
        end else if (xfer) begin
            sum  <= sum + Dout;
            slot <= (slot == LAST_SLOT) ? 5'd0 : slot + 5'd1;
        end
    end

    // Byte outputs are forced to zero whenever nothing is being offered.
    always_comb begin
        DoutValid = (state == SEND);
        Dout      = '0;
        DoutIndex = '0;
        DoutLast  = 1'b0;
        if (DoutValid) begin
            Dout      = snap[slot];
            DoutIndex = slot;
            DoutLast  = (slot == LAST_SLOT);
        end
    end

    assign Busy    = (state == SEND) || (state == DONE);
    assign Done    = (state == DONE);
    assign DumpSum = sum;

endmodule

// File: tb/tb_register_dump.sv
// tb_register_dump: table-driven dumps plus hand-written abort, reset,
// held-request and snapshot-freeze sequences for register_dump.
module tb_register_dump;

    logic        Clk = 1'b0;
    logic        notReset;
    logic        DumpReq;
    logic        Abort;
    logic [7:0]  notA, notF, notB, notC, notD, notE, notH, notL, notI, notR;
    logic [15:0] notPC, notSP, notIX, notIY;
    logic [7:0]  Dout;
    logic        DoutValid;
    logic        DoutReady;
    logic [4:0]  DoutIndex;
    logic        DoutLast;
    logic        Busy;
    logic        Done;
    logic [7:0]  DumpSum;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  a, f, b, c, d, e, h, l, i, r;
        logic [15:0] pc, sp, ix, iy;
        bit          stall;     // DoutReady pattern 1,0,0,1,0,0,...
        bit          scramble;  // drive all inputs to ones after capture
        logic [7:0]  exp_sum;   // hand-computed modulo-256 byte sum
    } vec_t;

    vec_t vecs [3];

    register_dump dut (
        .Clk       (Clk),
        .notReset  (notReset),
        .DumpReq   (DumpReq),
        .Abort     (Abort),
        .notA      (notA),
        .notF      (notF),
        .notB      (notB),
        .notC      (notC),
        .notD      (notD),
        .notE      (notE),
        .notH      (notH),
        .notL      (notL),
        .notI      (notI),
        .notR      (notR),
        .notPC     (notPC),
        .notSP     (notSP),
        .notIX     (notIX),
        .notIY     (notIY),
        .Dout      (Dout),
        .DoutValid (DoutValid),
        .DoutReady (DoutReady),
        .DoutIndex (DoutIndex),
        .DoutLast  (DoutLast),
        .Busy      (Busy),
        .Done      (Done),
        .DumpSum   (DumpSum)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [7:0] slot_byte(input vec_t v, input int s);
        case (s)
            0:  return v.a;
            1:  return v.f;
            2:  return v.b;
            3:  return v.c;
            4:  return v.d;
            5:  return v.e;
            6:  return v.h;
            7:  return v.l;
            8:  return v.pc[15:8];
            9:  return v.pc[7:0];
            10: return v.sp[15:8];
            11: return v.sp[7:0];
            12: return v.ix[15:8];
            13: return v.ix[7:0];
            14: return v.iy[15:8];
            15: return v.iy[7:0];
            16: return v.i;
            default: return v.r;
        endcase
    endfunction

    task automatic apply_regs(input vec_t v);
        notA = ~v.a;  notF = ~v.f;  notB = ~v.b;  notC = ~v.c;
        notD = ~v.d;  notE = ~v.e;  notH = ~v.h;  notL = ~v.l;
        notI = ~v.i;  notR = ~v.r;
        notPC = ~v.pc; notSP = ~v.sp; notIX = ~v.ix; notIY = ~v.iy;
    endtask

    task automatic scramble_regs();
        notA = '1; notF = '1; notB = '1; notC = '1; notD = '1;
        notE = '1; notH = '1; notL = '1; notI = '1; notR = '1;
        notPC = '1; notSP = '1; notIX = '1; notIY = '1;
    endtask

    task automatic start_dump(input vec_t v);
        apply_regs(v);
        DumpReq = 1'b1;
        step();
        DumpReq = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".valid"}, DoutValid, 0);
        check({tag, ".dout"},  Dout,      0);
        check({tag, ".index"}, DoutIndex, 0);
        check({tag, ".last"},  DoutLast,  0);
        check({tag, ".busy"},  Busy,      0);
        check({tag, ".done"},  Done,      0);
    endtask

    task automatic run_dump(input vec_t v, input int n);
        int idx = 0;
        int cyc = 0;
        DoutReady = 1'b0;
        start_dump(v);
        if (v.scramble) scramble_regs();
        while (idx < 18 && cyc < 200) begin
            DoutReady = v.stall ? (cyc % 3 == 0) : 1'b1;
            check($sformatf("v%0d.valid[%0d]", n, idx), DoutValid, 1);
            check($sformatf("v%0d.dout[%0d]",  n, idx), Dout,      slot_byte(v, idx));
            check($sformatf("v%0d.index[%0d]", n, idx), DoutIndex, idx);
            check($sformatf("v%0d.last[%0d]",  n, idx), DoutLast,  idx == 17);
            check($sformatf("v%0d.busy[%0d]",  n, idx), Busy,      1);
            if (DoutReady) idx++;
            cyc++;
            step();
        end
        DoutReady = 1'b0;
        check($sformatf("v%0d.bytes_sent", n), idx, 18);
        if (!v.stall) check($sformatf("v%0d.send_cycles", n), cyc, 18);
        check($sformatf("v%0d.done_pulse", n), Done,      1);
        check($sformatf("v%0d.done_busy", n),  Busy,      1);
        check($sformatf("v%0d.done_valid", n), DoutValid, 0);
        check($sformatf("v%0d.sum", n),        DumpSum,   v.exp_sum);
        step();
        check($sformatf("v%0d.done_clear", n), Done, 0);
        check($sformatf("v%0d.idle_busy", n),  Busy, 0);
        check($sformatf("v%0d.sum_hold", n),   DumpSum, v.exp_sum);
    endtask

    initial begin
        // 0x12+0x34+0x01..0x06+0xAB+0xCD+0xFF+0xFE+0x10+0x00+0x20+0x00+0x3F+0x7F = 0x4BE
        vecs[0] = '{8'h12, 8'h34, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h3F, 8'h7F,
                    16'hABCD, 16'hFFFE, 16'h1000, 16'h2000, 1'b0, 1'b1, 8'hBE};
        vecs[1] = '{8'h12, 8'h34, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h3F, 8'h7F,
                    16'hABCD, 16'hFFFE, 16'h1000, 16'h2000, 1'b1, 1'b0, 8'hBE};
        // 18 * 0x80 = 0x900 wraps to 0x00
        vecs[2] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80,
                    16'h8080, 16'h8080, 16'h8080, 16'h8080, 1'b0, 1'b0, 8'h00};

        notReset  = 1'b0;
        DumpReq   = 1'b0;
        Abort     = 1'b0;
        DoutReady = 1'b0;
        apply_regs(vecs[0]);
        #3;
        check_idle_outputs("reset");
        check("reset.sum", DumpSum, 0);
        @(negedge Clk);
        notReset = 1'b1;
        step();

        // Table-driven full dumps.
        for (int n = 0; n < 3; n++) begin
            run_dump(vecs[n], n);
        end

        // DumpReq together with Abort in IDLE: stays idle.
        DumpReq = 1'b1;
        Abort   = 1'b1;
        step();
        DumpReq = 1'b0;
        Abort   = 1'b0;
        check_idle_outputs("req_abort_idle");

        // Abort while slot 5 is offered with DoutReady high.
        DoutReady = 1'b1;
        start_dump(vecs[0]);
        repeat (5) step();
        check("abort.slot", DoutIndex, 5);
        Abort = 1'b1;
        step();
        Abort     = 1'b0;
        DoutReady = 1'b0;
        check_idle_outputs("abort");
        check("abort.sum", DumpSum, 8'h4C);
        step();
        check("abort.no_done", Done, 0);
        check("abort.sum_hold", DumpSum, 8'h4C);

        // DumpReq held high: one dump, one IDLE cycle, then a second dump.
        apply_regs(vecs[0]);
        DoutReady = 1'b1;
        DumpReq   = 1'b1;
        step();
        check("held.first_index", DoutIndex, 0);
        repeat (9) step();
        check("held.mid_index", DoutIndex, 9);
        repeat (9) step();
        check("held.done", Done, 1);
        check("held.sum", DumpSum, 8'hBE);
        step();
        check("held.idle_busy", Busy, 0);
        check("held.idle_valid", DoutValid, 0);
        step();
        check("held.restart_valid", DoutValid, 1);
        check("held.restart_index", DoutIndex, 0);
        check("held.restart_dout", Dout, 8'h12);
        check("held.restart_sum", DumpSum, 0);
        DumpReq = 1'b0;
        Abort   = 1'b1;
        step();
        Abort = 1'b0;

        // Reset pulsed while slot 9 is offered.
        start_dump(vecs[0]);
        repeat (9) step();
        check("rst_mid.slot", DoutIndex, 9);
        check("rst_mid.dout", Dout, 8'hCD);
        #2;
        notReset = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        check("rst_mid.sum", DumpSum, 0);
        step();
        check("rst_mid.no_done", Done, 0);
        @(negedge Clk);
        notReset = 1'b1;
        step();
        check("rst_mid.still_idle", Busy, 0);
        DoutReady = 1'b0;
        start_dump(vecs[0]);
        check("rst_mid.restart_index", DoutIndex, 0);
        check("rst_mid.restart_dout", Dout, 8'h12);
        step();
        check("rst_mid.stall_hold", DoutIndex, 0);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        check("rst_mid.abort_done", Done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
